// File: rtl/bcd_to_7segment_pkg.sv
// Shared seven-segment types and glyph constants (bit 6 = a ... bit 0 = g).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_DIGIT_0 = 7'b1111110;
  localparam seg7_t SEG_DIGIT_1 = 7'b0110000;
  localparam seg7_t SEG_DIGIT_2 = 7'b1101101;
  localparam seg7_t SEG_DIGIT_3 = 7'b1111001;
  localparam seg7_t SEG_DIGIT_4 = 7'b0110011;
  localparam seg7_t SEG_DIGIT_5 = 7'b1011011;
  localparam seg7_t SEG_DIGIT_6 = 7'b1011111;
  localparam seg7_t SEG_DIGIT_7 = 7'b1110000;
  localparam seg7_t SEG_DIGIT_8 = 7'b1111111;
  localparam seg7_t SEG_DIGIT_9 = 7'b1111011;
  localparam seg7_t SEG_BLANK   = 7'b0000000;

endpackage

// File: rtl/bcd_to_7segment_decode.sv
// Combinational BCD to segment pattern decode; codes 10-15 (and X/Z) blank with invalid flag.
module bcd_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg,
  output logic       o_invalid
);

  always_comb begin
    o_seg     = SEG_BLANK;
    o_invalid = 1'b0;
    case (i_bcd)
      4'd0:    o_seg = SEG_DIGIT_0;
      4'd1:    o_seg = SEG_DIGIT_1;
      4'd2:    o_seg = SEG_DIGIT_2;
      4'd3:    o_seg = SEG_DIGIT_3;
      4'd4:    o_seg = SEG_DIGIT_4;
      4'd5:    o_seg = SEG_DIGIT_5;
      4'd6:    o_seg = SEG_DIGIT_6;
      4'd7:    o_seg = SEG_DIGIT_7;
      4'd8:    o_seg = SEG_DIGIT_8;
      4'd9:    o_seg = SEG_DIGIT_9;
      default: begin
        o_seg     = SEG_BLANK;
        o_invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bcd_to_7segment.sv
// Registered BCD to seven-segment decoder with error flag.
// Define SEG_ACTIVE_LOW_EN for common-anode (inverted) segment outputs.
module bcd_to_7segment
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] BCD,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       error
);

  logic [6:0] w_seg;
  logic       w_invalid;
  logic [6:0] w_seg_drive;
  logic [6:0] w_seg_off;
  logic [6:0] r_seg;
  logic       r_error;

  bcd_seg_decode u_decode (
    .i_bcd     (BCD),
    .o_seg     (w_seg),
    .o_invalid (w_invalid)
  );

  // Polarity is applied before the register so pads see a clean flop output.
`ifdef SEG_ACTIVE_LOW_EN
  assign w_seg_drive = ~w_seg;
  assign w_seg_off   = ~SEG_BLANK;
`else
  assign w_seg_drive = w_seg;
  assign w_seg_off   = SEG_BLANK;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg   <= w_seg_off;
      r_error <= 1'b0;
    end else begin
      r_seg   <= w_seg_drive;
      r_error <= w_invalid;
    end
  end

  assign a     = r_seg[6];
  assign b     = r_seg[5];
  assign c     = r_seg[4];
  assign d     = r_seg[3];
  assign e     = r_seg[2];
  assign f     = r_seg[1];
  assign g     = r_seg[0];
  assign error = r_error;

endmodule

// File: tb/tb_bcd_to_7segment.sv
// Directed bench for bcd_to_7segment; expectations come from a hand-written glyph table.
module tb_bcd_to_7segment;

  logic       clk;
  logic       rst;
  logic [3:0] bcd;
  logic       a, b, c, d, e, f, g, error;

  int n_total = 0;
  int n_bad   = 0;

  // abcdefg patterns for digits 0-9, written out independently of the package
  logic [6:0] glyph [10];

  bcd_to_7segment dut (
    .clk   (clk),
    .rst   (rst),
    .BCD   (bcd),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .error (error)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pol(input logic [6:0] lit);
`ifdef SEG_ACTIVE_LOW_EN
    return ~lit;
`else
    return lit;
`endif
  endfunction

  task automatic check_out(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got segs=%b err=%b, want segs=%b err=%b",
               tag, obs[7:1], obs[0], exp[7:1], exp[0]);
    end
  endtask

  // driver: apply inputs away from the edge, let one posedge capture, sample on negedge
  task automatic step(input logic [3:0] v, input logic r);
    bcd = v;
    rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] observed();
    return {a, b, c, d, e, f, g, error};
  endfunction

  initial begin
    glyph[0] = 7'b1111110;
    glyph[1] = 7'b0110000;
    glyph[2] = 7'b1101101;
    glyph[3] = 7'b1111001;
    glyph[4] = 7'b0110011;
    glyph[5] = 7'b1011011;
    glyph[6] = 7'b1011111;
    glyph[7] = 7'b1110000;
    glyph[8] = 7'b1111111;
    glyph[9] = 7'b1111011;

    bcd = 4'd8;
    rst = 1'b1;
    @(negedge clk);

    step(4'd8, 1'b1);
    step(4'd8, 1'b1);
    check_out("reset_hold", observed(), {pol(7'b0000000), 1'b0});
    step(4'd8, 1'b0);
    check_out("reset_release_8", observed(), {pol(7'b1111111), 1'b0});

    for (int i = 0; i < 10; i++) begin
      step(4'(i), 1'b0);
      check_out($sformatf("digit_%0d", i), observed(), {pol(glyph[i]), 1'b0});
    end

    step(4'd1, 1'b0);
    check_out("spot_1_bc", observed(), {pol(7'b0110000), 1'b0});
    step(4'd7, 1'b0);
    check_out("spot_7_abc", observed(), {pol(7'b1110000), 1'b0});
    step(4'd6, 1'b0);
    check_out("spot_6_acdefg", observed(), {pol(7'b1011111), 1'b0});

    for (int i = 10; i < 16; i++) begin
      step(4'(i), 1'b0);
      check_out($sformatf("invalid_%0d", i), observed(), {pol(7'b0000000), 1'b1});
    end

    step(4'd9, 1'b0);
    check_out("alt_9", observed(), {pol(7'b1111011), 1'b0});
    step(4'd10, 1'b0);
    check_out("alt_10", observed(), {pol(7'b0000000), 1'b1});
    step(4'd0, 1'b0);
    check_out("alt_0", observed(), {pol(7'b1111110), 1'b0});

    step(4'd15, 1'b1);
    check_out("midreset_15", observed(), {pol(7'b0000000), 1'b0});
    step(4'd15, 1'b0);
    check_out("release_15", observed(), {pol(7'b0000000), 1'b1});

    step(4'd3, 1'b0);
    check_out("after_3", observed(), {pol(7'b1111001), 1'b0});
    step(4'd5, 1'b1);
    check_out("reset_over_5", observed(), {pol(7'b0000000), 1'b0});
    step(4'd5, 1'b0);
    check_out("release_5", observed(), {pol(7'b1011011), 1'b0});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
